// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between N_REQ requesters; optional ALU_ARB_ILLEGAL_OP_EN adds rsp_err.
// Latency: 1 cycle from accept to rsp_valid; one ALU op per cycle.
// Backpressure: a requester whose response slot is full and not being drained is skipped, others proceed.
module alu_share_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_x,
  input  logic [N_REQ*32-1:0] req_y,
  input  logic [N_REQ*4-1:0]  req_op,
  output logic [31:0]         alu_x,
  output logic [31:0]         alu_y,
  output logic [3:0]          alu_ctrl,
  input  logic [31:0]         alu_result,
  input  logic                alu_zero,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [N_REQ*32-1:0] rsp_result,
  output logic [N_REQ-1:0]    rsp_zero,
`ifdef ALU_ARB_ILLEGAL_OP_EN
  output logic [N_REQ-1:0]    rsp_err,
`endif
  output logic [IDXW-1:0]     grant_idx
);

  localparam logic [3:0] OP_ADD = 4'b0000;

  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [N_REQ*32-1:0] rsp_result_q, rsp_result_d;
  logic [N_REQ-1:0]    rsp_zero_q, rsp_zero_d;
  logic [N_REQ-1:0]    rsp_err_q, rsp_err_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [IDXW-1:0]     grant_q, grant_d;

  logic [N_REQ-1:0] elig;
  logic             gnt_vld;
  logic [IDXW-1:0]  gnt_idx;
  logic [IDXW-1:0]  cand;
  logic [31:0]      sel_x, sel_y;
  logic [3:0]       sel_op;
  logic             op_ok;
  logic [31:0]      cap_result;
  logic             cap_zero;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  assign op_ok   = op_legal(sel_op);
  assign rsp_err = rsp_err_q;
`else
  assign op_ok   = 1'b1;
`endif

  // Search starts one past the last winner so a waiting requester is served within N_REQ-1 grants.
  always_comb begin
    elig    = req_valid & (~rsp_valid_q | rsp_ready);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_op    = OP_ADD;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vld && gnt_idx == IDXW'(i)) begin
        req_ready[i] = 1'b1;
        sel_x        = req_x[32*i +: 32];
        sel_y        = req_y[32*i +: 32];
        sel_op       = req_op[4*i +: 4];
      end
    end
  end

  // Illegal ops never reach the ALU; the slot gets a fixed zero result instead.
  always_comb begin
    alu_x      = '0;
    alu_y      = '0;
    alu_ctrl   = OP_ADD;
    cap_result = '0;
    cap_zero   = 1'b1;
    if (gnt_vld && op_ok) begin
      alu_x      = sel_x;
      alu_y      = sel_y;
      alu_ctrl   = sel_op;
      cap_result = alu_result;
      cap_zero   = alu_zero;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q & ~rsp_ready;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vld && gnt_idx == IDXW'(i)) begin
        rsp_valid_d[i]          = 1'b1;
        rsp_result_d[32*i +: 32] = cap_result;
        rsp_zero_d[i]           = cap_zero;
        rsp_err_d[i]            = ~op_ok;
      end
    end
    if (gnt_vld) begin
      ptr_d   = gnt_idx;
      grant_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
      rsp_err_q    <= '0;
      ptr_q        <= IDXW'(N_REQ - 1);
      grant_q      <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign grant_idx  = grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and a behavioural ALU.
module tb_alu_share_arbiter;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLL = 4'b0001, SLT = 4'b0010,
                         SLTU = 4'b0011, XOR = 4'b0100, SRA = 4'b1101, OR = 4'b0110,
                         AND = 4'b0111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_zero;
  logic [63:0] req_x = '0, req_y = '0, rsp_result;
  logic [7:0]  req_op = '0;
  logic [31:0] alu_x, alu_y, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic [0:0]  grant_idx;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic [1:0]  rsp_err;
`endif

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
`ifdef ALU_ARB_ILLEGAL_OP_EN
    .rsp_err(rsp_err),
`endif
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      SUB:     alu_result = alu_x - alu_y;
      SLL:     alu_result = alu_x << alu_y[4:0];
      SLT:     alu_result = {31'd0, $signed(alu_x) < $signed(alu_y)};
      SLTU:    alu_result = {31'd0, alu_x < alu_y};
      XOR:     alu_result = alu_x ^ alu_y;
      4'b0101: alu_result = alu_x >> alu_y[4:0];
      SRA:     alu_result = $unsigned($signed(alu_x) >>> alu_y[4:0]);
      OR:      alu_result = alu_x | alu_y;
      AND:     alu_result = alu_x & alu_y;
      default: alu_result = alu_x + alu_y;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  rv, rr;
    logic [31:0] x0, y0;
    logic [3:0]  op0;
    logic [31:0] x1, y1;
    logic [3:0]  op1;
    logic [1:0]  e_rdy, e_vld;
    logic [31:0] e_res0, e_res1;
    logic [1:0]  e_zero;
    logic        e_gnt;
  } vec_t;

  vec_t v[14];

  task automatic drive(input logic [1:0] rv, input logic [1:0] rr,
                       input logic [31:0] x0, input logic [31:0] y0, input logic [3:0] op0,
                       input logic [31:0] x1, input logic [31:0] y1, input logic [3:0] op1);
    req_valid = rv;
    rsp_ready = rr;
    req_x     = {x1, x0};
    req_y     = {y1, y0};
    req_op    = {op1, op0};
  endtask

  initial begin
    v[0]  = '{2'b01, 2'b11, 5, 3, SUB, 0, 0, ADD,                        2'b01, 2'b01, 2, 0, 2'b00, 1'b0};
    v[1]  = '{2'b00, 2'b11, 0, 0, ADD, 0, 0, ADD,                        2'b00, 2'b00, 2, 0, 2'b00, 1'b0};
    v[2]  = '{2'b11, 2'b11, 1, 1, ADD, 2, 2, ADD,                        2'b10, 2'b10, 2, 4, 2'b00, 1'b1};
    v[3]  = '{2'b11, 2'b11, 1, 1, ADD, 2, 2, ADD,                        2'b01, 2'b01, 2, 4, 2'b00, 1'b0};
    v[4]  = '{2'b11, 2'b11, 1, 1, ADD, 2, 2, ADD,                        2'b10, 2'b10, 2, 4, 2'b00, 1'b1};
    v[5]  = '{2'b01, 2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, XOR, 0, 0, ADD,  2'b01, 2'b01, 0, 4, 2'b01, 1'b0};
    v[6]  = '{2'b01, 2'b11, 32'h80000000, 4, SRA, 0, 0, ADD,             2'b01, 2'b01, 32'hF8000000, 4, 2'b00, 1'b0};
    v[7]  = '{2'b11, 2'b11, 1, 4, SLL, 10, 3, SUB,                       2'b10, 2'b10, 32'hF8000000, 7, 2'b00, 1'b1};
    v[8]  = '{2'b01, 2'b11, 32'hF0, 32'h0F, OR, 0, 0, ADD,               2'b01, 2'b01, 32'hFF, 7, 2'b00, 1'b0};
    v[9]  = '{2'b10, 2'b01, 0, 0, ADD, 32'hFFFFFFFF, 1, SLT,             2'b10, 2'b10, 32'hFF, 1, 2'b00, 1'b1};
    v[10] = '{2'b11, 2'b01, 32'hFF, 32'h0F, AND, 9, 9, SUB,              2'b01, 2'b11, 32'h0F, 1, 2'b00, 1'b0};
    v[11] = '{2'b11, 2'b01, 3, 4, ADD, 9, 9, SUB,                        2'b01, 2'b11, 7, 1, 2'b00, 1'b0};
    v[12] = '{2'b11, 2'b11, 3, 4, ADD, 9, 9, SUB,                        2'b10, 2'b10, 7, 0, 2'b10, 1'b1};
    v[13] = '{2'b00, 2'b11, 0, 0, ADD, 0, 0, ADD,                        2'b00, 2'b00, 7, 0, 2'b10, 1'b1};

    #12;
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_result", rsp_result, 64'd0);
    chk("reset_rsp_zero", rsp_zero, 2'b00);
    chk("reset_grant_idx", grant_idx, 1'b0);
    chk("idle_alu_x", alu_x, 32'd0);
    chk("idle_alu_ctrl", alu_ctrl, ADD);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(v[i].rv, v[i].rr, v[i].x0, v[i].y0, v[i].op0, v[i].x1, v[i].y1, v[i].op1);
      #1;
      chk($sformatf("v%0d_req_ready", i), req_ready, v[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, v[i].e_vld);
      chk($sformatf("v%0d_rsp_result0", i), rsp_result[31:0], v[i].e_res0);
      chk($sformatf("v%0d_rsp_result1", i), rsp_result[63:32], v[i].e_res1);
      chk($sformatf("v%0d_rsp_zero", i), rsp_zero, v[i].e_zero);
      chk($sformatf("v%0d_grant_idx", i), grant_idx, v[i].e_gnt);
    end

    // Async reset between edges discards a pending response at once.
    @(negedge clk);
    drive(2'b01, 2'b00, 1, 2, ADD, 0, 0, ADD);
    @(posedge clk);
    #1;
    chk("pre_rst_rsp_valid", rsp_valid, 2'b01);
    chk("pre_rst_result0", rsp_result[31:0], 32'd3);
    drive(2'b00, 2'b00, 0, 0, ADD, 0, 0, ADD);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rst_result", rsp_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 2'b11, 6, 1, SUB, 7, 1, ADD);
    #1;
    chk("post_rst_req_ready", req_ready, 2'b01);
    chk("post_rst_alu_x", alu_x, 32'd6);
    chk("post_rst_alu_ctrl", alu_ctrl, SUB);
    @(posedge clk);
    #1;
    chk("post_rst_result0", rsp_result[31:0], 32'd5);

`ifdef ALU_ARB_ILLEGAL_OP_EN
    @(negedge clk);
    drive(2'b01, 2'b11, 5, 6, 4'b1001, 0, 0, ADD);
    #1;
    chk("illegal_req_ready", req_ready, 2'b01);
    chk("illegal_alu_ctrl", alu_ctrl, ADD);
    chk("illegal_alu_x", alu_x, 32'd0);
    @(posedge clk);
    #1;
    chk("illegal_rsp_valid", rsp_valid[0], 1'b1);
    chk("illegal_rsp_err", rsp_err[0], 1'b1);
    chk("illegal_rsp_result", rsp_result[31:0], 32'd0);
    chk("illegal_rsp_zero", rsp_zero[0], 1'b1);
    @(negedge clk);
    drive(2'b01, 2'b11, 32'hF, 32'h3, AND, 0, 0, ADD);
    @(posedge clk);
    #1;
    chk("legal_rsp_err", rsp_err[0], 1'b0);
    chk("legal_rsp_result", rsp_result[31:0], 32'd3);
`endif

    @(negedge clk);
    drive(2'b00, 2'b11, 0, 0, ADD, 0, 0, ADD);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between N_REQ requesters, e.g. the execute stage and the branch/address-generation path.
- Each requester uses a valid/ready request channel and a registered valid/ready response slot.
- The block sequences one ALU operation per cycle, chosen by round-robin.
- It drives the ALU operand and control inputs and captures the ALU result and zero flag.

Parameters:
- N_REQ, 2, number of requesters (legal range 2..4).
- IDXW, $clog2(N_REQ), width of the grant index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  request i valid.
- req_ready  out  N_REQ  request i accepted this cycle.
- req_x  in  N_REQ*32  operand x, slice i = [32*i +: 32].
- req_y  in  N_REQ*32  operand y, slice i.
- req_op  in  N_REQ*4  ALU control code, slice i = [4*i +: 4].
- alu_x  out  32  to ALU x.
- alu_y  out  32  to ALU y.
- alu_ctrl  out  4  to ALU ALUControl.
- alu_result  in  32  from ALU.
- alu_zero  in  1  from ALU.
- rsp_valid  out  N_REQ  response slot i holds a result.
- rsp_ready  in  N_REQ  requester i consumes its response.
- rsp_result  out  N_REQ*32  registered result, slice i.
- rsp_zero  out  N_REQ  registered zero flag.
- grant_idx  out  IDXW  index of the last accepted requester (debug).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: rsp_valid=0, rsp_result=0, rsp_zero=0, priority pointer ptr=N_REQ-1 (requester 0 has first priority after reset), grant_idx=0.
- Reset mid-operation: any pending response is discarded, with no partial result visible.
- ALU op codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. All other codes are illegal.
- Slot free: free[i] = !rsp_valid[i] || rsp_ready[i].
- Eligibility: requester i is eligible when req_valid[i] && free[i].
- Arbitration is combinational and round-robin.
  - Search order is ptr+1, ptr+2, ... (mod N_REQ).
  - The first eligible index is granted.
  - At most one grant per cycle.
- req_ready[i] = 1 only for the granted index. It depends on req_valid, which is allowed in this design.
- Acceptance: a request is accepted when req_valid[i] && req_ready[i].
- ALU drive when a grant exists: alu_x/alu_y/alu_ctrl = slices of the granted requester.
- ALU drive when there is no grant: alu_x=0, alu_y=0, alu_ctrl=ADD.
- Latency: on an accept in cycle N, at the clk edge ending cycle N:
  - rsp_result[i] <= alu_result;
  - rsp_zero[i] <= alu_zero;
  - rsp_valid[i] <= 1;
  - ptr <= i;
  - grant_idx <= i.
  - The response is visible in cycle N+1, so result latency is 1 cycle.
- Response drain: if rsp_valid[i] && rsp_ready[i] with no new accept for i, rsp_valid[i] <= 0. rsp_result holds its value.
- Simultaneous drain and accept on the same slot: rsp_valid stays 1 and data is replaced by the new result. Back-to-back throughput is 1 op/cycle per requester if it is the only one active.
- Full slot: while rsp_valid[i]=1 and rsp_ready[i]=0, requester i is not eligible. Other requesters proceed with no head-of-line blocking.
- Fairness: a continuously eligible requester waits at most N_REQ-1 grants. ptr does not move on idle cycles.
- Requester rule: req_x/req_y/req_op are held stable while req_valid && !req_ready. The block keeps no copy of unaccepted requests.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_OP_EN.
- When defined:
  - Adds output rsp_err (N_REQ, reset 0).
  - An accepted request with an illegal op code is not sent to the ALU: alu_ctrl=ADD, alu_x=alu_y=0.
  - The slot captures rsp_result=0, rsp_zero=1, rsp_err[i]=1.
  - A legal op captures rsp_err[i]=0.
  - rsp_err follows rsp_valid timing.
- When undefined:
  - No rsp_err port.
  - Op codes are passed to the ALU unchecked, and the ALU's behaviour for illegal codes determines the result.

Test Plan:
- Reset then single request: req0 x=5, y=3, op=SUB, rsp_ready0=1 -> req_ready0=1 in cycle 0; cycle 1 rsp_valid0=1, rsp_result0=2, rsp_zero0=0; cycle 2 rsp_valid0=0.
- Contention: req0 and req1 valid every cycle with ADD 1+1 and ADD 2+2, both rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; rsp_result0=2, rsp_result1=4 each on alternate cycles.
- Backpressure: req1 SLT x=0xFFFFFFFF, y=1, rsp_ready1=0 -> result 1 held; second req1 stays unaccepted (req_ready1=0) while req0 ops continue each cycle; raise rsp_ready1 -> req1 accepted the same cycle the old response drains, and rsp_valid1 stays 1.
- Zero flag and shift: req0 XOR x=y=0xA5A5A5A5 -> rsp_zero0=1, result 0. req0 SRA x=0x80000000, y=4 -> result 0xF8000000.
- Async reset mid-stream: assert rst between edges with rsp_valid0=1 -> rsp_valid0=0 immediately; after release, first grant goes to req0 when both are valid.
- With ALU_ARB_ILLEGAL_OP_EN: req0 op=1001 -> rsp_valid0=1, rsp_err0=1, rsp_result0=0, alu_ctrl=0000 during the accept cycle; next op AND returns rsp_err0=0.
